// File: rtl/spi_minion_adapter_param.sv
// SPI minion with valid/ready recv/send queues and a loopthrough echo path.
// Optional parity outputs are enabled by defining SPI_ADAPTER_PARITY_EN.
`timescale 1ns/1ps
module spi_minion_adapter_param #(
    parameter int BITS  = 32,
    parameter int DEPTH = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            spi_cs,
    input  logic            spi_sclk,
    input  logic            spi_mosi,
    output logic            spi_miso,
    output logic            miso_oeb,
    input  logic            loopthrough_sel,
    output logic [BITS-1:0] recv_msg,
    output logic            recv_val,
    input  logic            recv_rdy,
    input  logic [BITS-1:0] send_msg,
    input  logic            send_val,
    output logic            send_rdy,
    output logic            frame_err,
    output logic            adapter_parity,
    output logic            minion_parity
);
    localparam int PW   = BITS + 2;
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int QCW  = $clog2(DEPTH + 1);
    localparam int BCW  = $clog2(PW + 2);
    localparam logic [BCW-1:0]  FRAME_LEN = BCW'(PW);
    localparam logic [BCW-1:0]  CNT_SAT   = BCW'(PW + 1);
    localparam logic [PTRW-1:0] PTR_LAST  = PTRW'(DEPTH - 1);
    localparam logic [QCW-1:0]  Q_FULL    = QCW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_COMMIT = 2'd2} state_t;

    function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
        ptr_next = (p == PTR_LAST) ? {PTRW{1'b0}} : p + PTRW'(1);
    endfunction

    logic [1:0] cs_sync_r, sclk_sync_r, mosi_sync_r;
    logic       cs_prev_r, sclk_prev_r;
    logic       cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;

    state_t          state_r, state_n;
    logic [BCW-1:0]  bit_cnt_r, bit_cnt_n;
    logic [PW-1:0]   shift_in_r, shift_in_n, shift_out_r, shift_out_n;
    logic            space_snap_r, space_snap_n, avail_snap_r, avail_snap_n;
    logic            commit_ok_s;

    logic [BITS-1:0] rq_mem_r [DEPTH];
    logic [BITS-1:0] sq_mem_r [DEPTH];
    logic [PTRW-1:0] rq_head_r, rq_tail_r, sq_head_r, sq_tail_r;
    logic [QCW-1:0]  rq_cnt_r, sq_cnt_r;
    logic            rq_empty_s, rq_full_s, sq_empty_s, sq_full_s;
    logic            rq_push_s, rq_pop_s, sq_push_s, sq_pop_s, loop_move_s;
    logic [BITS-1:0] sq_head_s, sq_din_s;

    // Two-flop synchronizers; reset low so a cs held low across reset is not seen as a new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync_r   <= 2'b00;
            sclk_sync_r <= 2'b00;
            mosi_sync_r <= 2'b00;
            cs_prev_r   <= 1'b0;
            sclk_prev_r <= 1'b0;
        end else begin
            cs_sync_r   <= {cs_sync_r[0], spi_cs};
            sclk_sync_r <= {sclk_sync_r[0], spi_sclk};
            mosi_sync_r <= {mosi_sync_r[0], spi_mosi};
            cs_prev_r   <= cs_sync_r[1];
            sclk_prev_r <= sclk_sync_r[1];
        end
    end

    assign cs_fall_s   = cs_prev_r & ~cs_sync_r[1];
    assign cs_rise_s   = ~cs_prev_r & cs_sync_r[1];
    assign sclk_rise_s = ~sclk_prev_r & sclk_sync_r[1];
    assign sclk_fall_s = sclk_prev_r & ~sclk_sync_r[1];

    assign rq_empty_s = (rq_cnt_r == QCW'(0));
    assign rq_full_s  = (rq_cnt_r == Q_FULL);
    assign sq_empty_s = (sq_cnt_r == QCW'(0));
    assign sq_full_s  = (sq_cnt_r == Q_FULL);
    assign sq_head_s  = sq_empty_s ? {BITS{1'b0}} : sq_mem_r[sq_head_r];

    // Frame FSM next-state: snapshot flags at cs fall, shift on sclk edges, decide at COMMIT.
    always_comb begin
        state_n      = state_r;
        bit_cnt_n    = bit_cnt_r;
        shift_in_n   = shift_in_r;
        shift_out_n  = shift_out_r;
        space_snap_n = space_snap_r;
        avail_snap_n = avail_snap_r;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_n      = ST_SHIFT;
                    bit_cnt_n    = {BCW{1'b0}};
                    shift_in_n   = {PW{1'b0}};
                    shift_out_n  = {~rq_full_s, ~sq_empty_s, sq_head_s};
                    space_snap_n = ~rq_full_s;
                    avail_snap_n = ~sq_empty_s;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    state_n = ST_COMMIT;
                end else begin
                    state_n = ST_SHIFT;
                    if (sclk_rise_s) begin
                        shift_in_n = {shift_in_r[PW-2:0], mosi_sync_r[1]};
                        // Saturate so an over-long frame can never wrap back to a valid length.
                        bit_cnt_n  = (bit_cnt_r == CNT_SAT) ? bit_cnt_r : bit_cnt_r + BCW'(1);
                    end else begin
                        shift_in_n = shift_in_r;
                    end
                    if (sclk_fall_s) begin
                        shift_out_n = {shift_out_r[PW-2:0], 1'b0};
                    end else begin
                        shift_out_n = shift_out_r;
                    end
                end
            end
            ST_COMMIT: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // Frame FSM registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= {BCW{1'b0}};
            shift_in_r   <= {PW{1'b0}};
            shift_out_r  <= {PW{1'b0}};
            space_snap_r <= 1'b0;
            avail_snap_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            bit_cnt_r    <= bit_cnt_n;
            shift_in_r   <= shift_in_n;
            shift_out_r  <= shift_out_n;
            space_snap_r <= space_snap_n;
            avail_snap_r <= avail_snap_n;
        end
    end

    assign commit_ok_s = (state_r == ST_COMMIT) && (bit_cnt_r == FRAME_LEN);
    assign frame_err   = (state_r == ST_COMMIT) && (bit_cnt_r != FRAME_LEN);
    assign spi_miso    = (state_r == ST_SHIFT) ? shift_out_r[PW-1] : 1'b0;
    assign miso_oeb    = (state_r != ST_SHIFT);

    assign recv_val    = ~reset & ~loopthrough_sel & ~rq_empty_s;
    assign send_rdy    = ~reset & ~loopthrough_sel & ~sq_full_s;
    assign recv_msg    = rq_mem_r[rq_head_r];
    assign loop_move_s = loopthrough_sel & ~rq_empty_s & ~sq_full_s;

    assign rq_push_s = commit_ok_s & shift_in_r[PW-1] & space_snap_r & (~rq_full_s | rq_pop_s);
    assign rq_pop_s  = loopthrough_sel ? loop_move_s : (recv_rdy & recv_val);
    assign sq_pop_s  = commit_ok_s & shift_in_r[PW-2] & avail_snap_r & ~sq_empty_s;
    assign sq_push_s = loopthrough_sel ? loop_move_s : (send_val & send_rdy);
    assign sq_din_s  = loopthrough_sel ? recv_msg : send_msg;

    // Queue storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        if (rq_push_s) begin
            rq_mem_r[rq_tail_r] <= shift_in_r[BITS-1:0];
        end
        if (sq_push_s) begin
            sq_mem_r[sq_tail_r] <= sq_din_s;
        end
    end

    // Queue pointers and occupancy counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            rq_head_r <= {PTRW{1'b0}};
            rq_tail_r <= {PTRW{1'b0}};
            rq_cnt_r  <= {QCW{1'b0}};
            sq_head_r <= {PTRW{1'b0}};
            sq_tail_r <= {PTRW{1'b0}};
            sq_cnt_r  <= {QCW{1'b0}};
        end else begin
            rq_tail_r <= rq_push_s ? ptr_next(rq_tail_r) : rq_tail_r;
            rq_head_r <= rq_pop_s  ? ptr_next(rq_head_r) : rq_head_r;
            sq_tail_r <= sq_push_s ? ptr_next(sq_tail_r) : sq_tail_r;
            sq_head_r <= sq_pop_s  ? ptr_next(sq_head_r) : sq_head_r;
            case ({rq_push_s, rq_pop_s})
                2'b10:   rq_cnt_r <= rq_cnt_r + QCW'(1);
                2'b01:   rq_cnt_r <= rq_cnt_r - QCW'(1);
                default: rq_cnt_r <= rq_cnt_r;
            endcase
            case ({sq_push_s, sq_pop_s})
                2'b10:   sq_cnt_r <= sq_cnt_r + QCW'(1);
                2'b01:   sq_cnt_r <= sq_cnt_r - QCW'(1);
                default: sq_cnt_r <= sq_cnt_r;
            endcase
        end
    end

`ifdef SPI_ADAPTER_PARITY_EN
    function automatic logic parity_f(input logic [BITS-1:0] d);
        parity_f = ^d;
    endfunction

    logic minion_parity_r;

    // Parity of the payload handed out by the most recent committed pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            minion_parity_r <= 1'b0;
        end else if (sq_pop_s) begin
            minion_parity_r <= parity_f(sq_mem_r[sq_head_r]);
        end else begin
            minion_parity_r <= minion_parity_r;
        end
    end

    assign adapter_parity = recv_val ? parity_f(recv_msg) : 1'b0;
    assign minion_parity  = minion_parity_r;
`else
    assign adapter_parity = 1'b0;
    assign minion_parity  = 1'b0;
`endif

endmodule
